// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: shift-add multiply and restoring divide over XLEN cycles,
// with magnitude arithmetic, sign fix-up in FIX and a fast path for divide special cases.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_count;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic                r_special;
  logic [XLEN-1:0]     r_spec_res;
  logic [XLEN-1:0]     r_result;

  logic [2:0]          w_f3;
  logic                w_accept, w_is_div, w_a_neg, w_b_neg, w_neg, w_special;
  logic [XLEN-1:0]     w_a_mag, w_b_mag, w_spec_res;
  logic [XLEN:0]       w_mul_sum, w_div_top, w_div_diff;
  logic [2*XLEN-1:0]   w_acc_next, w_prod;
  logic [XLEN-1:0]     w_quo, w_rem, w_fix_res;

  // Operand decode: signedness from funct3, then magnitudes and the result sign.
  always_comb begin
    w_f3       = alu_op[2:0];
    w_is_div   = w_f3[2];
    w_a_neg    = a[XLEN-1] && (w_f3 == 3'd1 || w_f3 == 3'd2 || w_f3 == 3'd4 || w_f3 == 3'd6);
    w_b_neg    = b[XLEN-1] && (w_f3 == 3'd1 || w_f3 == 3'd4 || w_f3 == 3'd6);
    w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
    w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
    w_neg      = (w_f3 == 3'd6) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_special  = 1'b0;
    w_spec_res = '0;
    if (w_is_div) begin
      if (b == '0) begin
        w_special  = 1'b1;
        w_spec_res = w_f3[1] ? a : '1;
      end else if (!w_f3[0] && a == MIN_INT && b == '1) begin
        w_special  = 1'b1;
        w_spec_res = w_f3[1] ? '0 : MIN_INT;
      end
    end
    w_accept = start && (alu_op[5:3] == 3'b100) && !flush &&
               (r_state == S_IDLE || r_state == S_DONE);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? (w_special ? S_FIX : S_CALC) : S_IDLE;
      S_CALC:         if (r_count == CW'(XLEN-1)) w_next = S_FIX;
      S_FIX:          w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // One iteration: multiply adds multiplicand into the high half and shifts right;
  // divide shifts {rem, quo} left and subtracts the divisor when it fits.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_top  = r_acc[2*XLEN-1:XLEN-1];
    w_div_diff = w_div_top - {1'b0, r_opnd};
    if (r_op[2]) begin
      w_acc_next = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                    : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
    end
    w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_neg ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    w_rem  = r_neg ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    case (r_op)
      3'd0:             w_fix_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_fix_res = w_quo;
      default:          w_fix_res = w_rem;
    endcase
    if (r_special) w_fix_res = r_spec_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_op       <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_result   <= '0;
    end else begin
      if (w_accept) begin
        r_count    <= '0;
        r_op       <= w_f3;
        r_neg      <= w_neg;
        r_special  <= w_special;
        r_spec_res <= w_spec_res;
        r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
        r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
      end else if (r_state == S_CALC) begin
        r_acc   <= w_acc_next;
        r_count <= r_count + 1'b1;
      end
      if (r_state == S_FIX && !flush) r_result <= w_fix_res;
    end
  end

  assign busy      = (r_state == S_CALC) || (r_state == S_FIX);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed corner cases plus random ops checked against a
// plain-arithmetic reference model; latency and control behaviour checked per scenario.
module tb_muldiv_seq;

  localparam logic [5:0] OP_MUL = 6'b100000, OP_MULH = 6'b100001, OP_MULHSU = 6'b100010,
                         OP_MULHU = 6'b100011, OP_DIV = 6'b100100, OP_DIVU = 6'b100101,
                         OP_REM = 6'b100110, OP_REMU = 6'b100111;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [5:0]  alu_op;
  logic [31:0] a, b, result;
  logic        busy, done;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux;
    logic [63:0] p;
    int si, sj;
    sx = $signed(x); sy = $signed(y); ux = longint'({32'b0, x});
    si = x; sj = y;
    case (op[2:0])
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = longint'(sy) * 0 + sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return si / sj;
      end
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        return si % sj;
      end
      default: return (y == 0) ? x : x % y;
    endcase
    if (ux < 0) return 32'h0;
  endfunction

  function automatic bit is_special(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    return op[2] && (y == 0 || (!op[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
  endfunction

  // driver tasks: all start and end at a falling edge
  task automatic issue(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; alu_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; alu_op = 6'($urandom_range(0, 63));
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bcnt, output bit seen);
    lat = lat0; bcnt = 0; seen = 1'b0;
    while (lat <= 200) begin
      if (busy) bcnt++;
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int bcnt, output bit seen);
    issue(op, x, y);
    wait_done(1, lat, bcnt, seen);
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset got busy=%b done=%b result=%h state=%0d exp 0/0/0/0", busy, done, result, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    logic [31:0] res; int lat, bcnt; bit seen;
    run_op(OP_MUL, 32'd30, 32'd7, res, lat, bcnt, seen);
    checks++;
    if (!seen || lat !== 34 || res !== 32'd210) begin
      failures++;
      $display("FAIL mul_basic got seen=%0d lat=%0d res=%0d exp lat=34 res=210", seen, lat, res);
    end
    checks++;
    if (bcnt !== 33) begin
      failures++;
      $display("FAIL mul_busy_cycles got=%0d exp=33", bcnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 32'd210) begin
      failures++;
      $display("FAIL mul_done_width got done=%b result=%0d exp done=0 result=210", done, result);
    end
  endtask

  task automatic test_mul_corners();
    logic [5:0]  ops [4] = '{OP_MULH, OP_MULHU, OP_MULHSU, OP_MUL};
    logic [31:0] exps[4] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1};
    logic [31:0] res; int lat, bcnt; bit seen;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, bcnt, seen);
      checks++;
      if (!seen || lat !== 34 || res !== exps[i]) begin
        failures++;
        $display("FAIL mul_corner[%0d] got seen=%0d lat=%0d res=%h exp lat=34 res=%h", i, seen, lat, res, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_basic();
    logic [5:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] xs  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd120, 32'd120};
    logic [31:0] ys  [4] = '{32'd2, 32'd2, 32'd10, 32'd10};
    logic [31:0] exps[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd12, 32'd0};
    logic [31:0] res; int lat, bcnt; bit seen;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xs[i], ys[i], res, lat, bcnt, seen);
      checks++;
      if (!seen || lat !== 34 || res !== exps[i]) begin
        failures++;
        $display("FAIL div_basic[%0d] got seen=%0d lat=%0d res=%h exp lat=34 res=%h", i, seen, lat, res, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_special();
    logic [5:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] xs  [4] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000};
    logic [31:0] ys  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exps[4] = '{32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h0};
    logic [31:0] res; int lat, bcnt; bit seen;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xs[i], ys[i], res, lat, bcnt, seen);
      checks++;
      if (!seen || lat !== 2 || bcnt !== 1 || res !== exps[i]) begin
        failures++;
        $display("FAIL div_special[%0d] got seen=%0d lat=%0d busy=%0d res=%h exp lat=2 busy=1 res=%h",
                 i, seen, lat, bcnt, res, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] res, x, y, e; logic [5:0] op; int lat, bcnt, elat; bit seen;
    for (int i = 0; i < 30; i++) begin
      op = {3'b100, 3'($urandom_range(0, 7))};
      x  = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1:       y = 32'($urandom_range(1, 15));
        2:       begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        3:       y = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: y = $urandom;
      endcase
      exp_q.push_back(model(op, x, y));
      elat = is_special(op, x, y) ? 2 : 34;
      run_op(op, x, y, res, lat, bcnt, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat !== elat || res !== e) begin
        failures++;
        $display("FAIL random[%0d] op=%b a=%h b=%h got seen=%0d lat=%0d res=%h exp lat=%0d res=%h",
                 i, op, x, y, seen, lat, res, elat, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res; int lat, bcnt; bit seen;
    issue(OP_MUL, 32'd30, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; alu_op = OP_DIVU; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, lat, bcnt, seen);
    res = result;
    checks++;
    if (!seen || lat !== 34 || res !== 32'd210) begin
      failures++;
      $display("FAIL start_while_busy got seen=%0d lat=%0d res=%0d exp lat=34 res=210", seen, lat, res);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_while_busy_after got busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat, bcnt, dcnt; bit seen;
    run_op(OP_MUL, 32'd5, 32'd5, res, lat, bcnt, seen);
    @(negedge clk);
    issue(OP_MUL, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd25) begin
      failures++;
      $display("FAIL flush got busy=%b done=%b result=%0d exp 0/0/25", busy, done, result);
    end
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL flush_no_done got active_cycles=%0d exp=0", dcnt);
    end
    start = 1'b1; flush = 1'b1; alu_op = OP_MUL; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL flush_start got busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_rst_mid();
    issue(OP_DIVU, 32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid got busy=%b done=%b result=%h exp 0/0/0", busy, done, result);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, dcnt; bit seen;
    issue(OP_MUL, 32'd3, 32'd4);
    wait_done(1, lat, bcnt, seen);
    checks++;
    if (!seen || lat !== 34 || result !== 32'd12) begin
      failures++;
      $display("FAIL b2b_first got seen=%0d lat=%0d res=%0d exp lat=34 res=12", seen, lat, result);
    end
    issue(OP_DIVU, 32'd9, 32'd2);
    wait_done(1, lat, bcnt, seen);
    checks++;
    if (!seen || lat !== 34 || result !== 32'd4) begin
      failures++;
      $display("FAIL b2b_second got seen=%0d lat=%0d res=%0d exp lat=34 res=4", seen, lat, result);
    end
    @(negedge clk);
    start = 1'b1; alu_op = 6'b000000; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    repeat (3) begin
      if (busy || done) dcnt++;
      @(negedge clk);
    end
    checks++;
    if (dcnt !== 0 || result !== 32'd4) begin
      failures++;
      $display("FAIL non_m_ignored got active_cycles=%0d result=%0d exp 0 and 4", dcnt, result);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_corners();
    test_div_basic();
    test_div_special();
    test_random();
    test_start_while_busy();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
